// File: rtl/cpu_csr_unit.sv
// CSR read-modify-write sequencer: IDLE -> READ -> WRITE -> DONE, fixed 3-cycle latency.
// Optional build macro CPU_CSR_RO_CHECK_EN makes writes to addr[11:10]==2'b11 illegal.
module cpu_csr_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [11:0] addr,
  input  logic [31:0] rs1_val,
  input  logic        rs1_is_x0,
  input  logic [4:0]  uimm,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] rd_val,
  output logic        retire,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_wr,
  input  logic [31:0] csr_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] src_q, src_d;
  logic        src_zero_q, src_zero_d;
  logic [31:0] old_q, old_d;
  logic [31:0] rd_val_q, rd_val_d;

  logic        need_write;
  logic        ro_violation;
  logic        op_illegal;

  // funct3[2] only selects the source at latch time, so just the op bits are kept.
  always_comb begin
    need_write = (op_q == 2'b01) || !src_zero_q;
`ifdef CPU_CSR_RO_CHECK_EN
    ro_violation = need_write && (addr_q[11:10] == 2'b11);
`else
    ro_violation = 1'b0;
`endif
    op_illegal = (op_q == 2'b00) || ro_violation;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    src_d      = src_q;
    src_zero_d = src_zero_q;
    old_d      = old_q;
    rd_val_d   = rd_val_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_READ;
          op_d       = funct3[1:0];
          addr_d     = addr;
          src_d      = funct3[2] ? {27'd0, uimm} : rs1_val;
          src_zero_d = funct3[2] ? (uimm == 5'd0) : rs1_is_x0;
        end
      end
      S_READ: begin
        state_d = S_WRITE;
        old_d   = csr_rdata;
      end
      S_WRITE: begin
        state_d  = S_DONE;
        rd_val_d = old_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (op_q)
      2'b10:   csr_wdata = old_q | src_q;
      2'b11:   csr_wdata = old_q & ~src_q;
      default: csr_wdata = src_q;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign illegal  = done && op_illegal;
  assign retire   = done && !op_illegal;
  assign csr_wr   = (state_q == S_WRITE) && !op_illegal && need_write;
  assign csr_addr = addr_q;
  assign rd_val   = rd_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      addr_q     <= 12'd0;
      src_q      <= 32'd0;
      src_zero_q <= 1'b0;
      old_q      <= 32'd0;
      rd_val_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      old_q      <= old_d;
      rd_val_q   <= rd_val_d;
    end
  end

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Self-checking bench for cpu_csr_unit: directed cases plus randomized ops against a
// behavioural CSR-file model (expectations follow CPU_CSR_RO_CHECK_EN if defined).
module tb_cpu_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [11:0] addr;
  logic [31:0] rs1_val;
  logic        rs1_is_x0;
  logic [4:0]  uimm;
  logic        busy, done, illegal, retire, csr_wr;
  logic [31:0] rd_val, csr_wdata, csr_rdata;
  logic [11:0] csr_addr;

  logic [31:0] ref_mem [0:4095];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  cpu_csr_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .addr(addr),
    .rs1_val(rs1_val), .rs1_is_x0(rs1_is_x0), .uimm(uimm),
    .busy(busy), .done(done), .illegal(illegal), .rd_val(rd_val), .retire(retire),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wr(csr_wr), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  assign csr_rdata = ref_mem[csr_addr];

  always @(posedge clk) begin
    if (csr_wr) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_retire"}, retire, 0);
    check({tag, "_csr_wr"}, csr_wr, 0);
    check({tag, "_rd_val"}, rd_val, 0);
    check({tag, "_csr_addr"}, {20'd0, csr_addr}, 0);
    check({tag, "_csr_wdata"}, csr_wdata, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r,
                        input logic x0, input logic [4:0] u, input bit spam);
    logic [31:0] src, old, exp_wdata;
    logic        zero, need, ro_bad, exp_ill, exp_wr;
    int          wr0, d0;
    src  = f3[2] ? {27'd0, u} : r;
    zero = f3[2] ? (u == 5'd0) : x0;
    old  = ref_mem[a];
    need = (f3[1:0] == 2'b01) || !zero;
`ifdef CPU_CSR_RO_CHECK_EN
    ro_bad = need && (a[11:10] == 2'b11);
`else
    ro_bad = 1'b0;
`endif
    exp_ill = (f3[1:0] == 2'b00) || ro_bad;
    exp_wr  = !exp_ill && need;
    case (f3[1:0])
      2'b10:   exp_wdata = old | src;
      2'b11:   exp_wdata = old & ~src;
      default: exp_wdata = src;
    endcase
    wr0 = wr_cnt;
    d0  = done_cnt;

    funct3 = f3; addr = a; rs1_val = r; rs1_is_x0 = x0; uimm = u; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = spam;
    if (spam) begin
      funct3 = 3'($urandom); addr = 12'($urandom); rs1_val = $urandom;
      rs1_is_x0 = 1'($urandom); uimm = 5'($urandom);
    end
    check("read_busy", busy, 1);
    check("read_done", done, 0);
    check("read_csr_wr", csr_wr, 0);
    check("read_csr_addr", {20'd0, csr_addr}, {20'd0, a});
    @(posedge clk); @(negedge clk);
    check("write_csr_wr", csr_wr, exp_wr);
    check("write_done", done, 0);
    if (exp_wr) check("write_csr_wdata", csr_wdata, exp_wdata);
    @(posedge clk); @(negedge clk);
    check("done_pulse", done, 1);
    check("done_illegal", illegal, exp_ill);
    check("done_retire", retire, !exp_ill);
    check("done_rd_val", rd_val, old);
    check("done_csr_wr", csr_wr, 0);
    check("done_busy", busy, 1);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("after_retire", retire, 0);
    check("after_rd_hold", rd_val, old);
    check("wr_count", wr_cnt - wr0, {31'd0, exp_wr});
    check("done_count", done_cnt - d0, 1);
    if (exp_wr) ref_mem[a] = exp_wdata;
  endtask

  initial begin
    int wr0, d0;
    logic [2:0]  f3;
    logic [11:0] a;
    logic        x0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; addr = 12'd0; rs1_val = 32'd0;
    rs1_is_x0 = 1'b0; uimm = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    ref_mem[12'h140] = 32'h12345678;
    run_op(3'b001, 12'h140, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    ref_mem[12'h100] = 32'h00000101;
    run_op(3'b010, 12'h100, 32'h0000000A, 1'b0, 5'd0, 1'b0);
    ref_mem[12'h100] = 32'h00000101;
    run_op(3'b011, 12'h100, 32'h0000000A, 1'b0, 5'd0, 1'b0);
    ref_mem[12'hC00] = 32'h00000055;
    run_op(3'b110, 12'hC00, 32'h0, 1'b0, 5'd0, 1'b0);
    run_op(3'b010, 12'hC00, 32'h0, 1'b1, 5'd0, 1'b0);
    run_op(3'b001, 12'hC01, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
    run_op(3'b100, 12'h305, 32'h11111111, 1'b0, 5'd3, 1'b1);
    run_op(3'b000, 12'h305, 32'h22222222, 1'b0, 5'd3, 1'b0);

    // Reset in the WRITE cycle of a CSRRW
    ref_mem[12'h200] = 32'h0;
    wr0 = wr_cnt; d0 = done_cnt;
    funct3 = 3'b001; addr = 12'h200; rs1_val = 32'hA5A5A5A5; rs1_is_x0 = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstw_csr_wr_before", csr_wr, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("rstw");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rstw_no_done", done_cnt - d0, 0);
    check("rstw_wr_count", wr_cnt - wr0, 1);
    ref_mem[12'h200] = 32'hA5A5A5A5;
    run_op(3'b011, 12'h200, 32'h0000FFFF, 1'b0, 5'd0, 1'b0);

    // start coincident with reset is dropped
    rst = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    @(posedge clk); @(negedge clk);
    check("rst_start_busy2", busy, 0);

    // Randomized ops
    for (int n = 0; n < 300; n++) begin
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
      x0 = ($urandom_range(0, 3) == 0);
      run_op(f3, a, x0 ? 32'd0 : $urandom, x0,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
